alu_decoder_md: RTL

Parametrised ALU decoder with an integrated iterative multiply/divide sequencer and HI/LO register pair, for the single-cycle MIPS datapath. Combinationally decodes `aluop`/`funct` into the 3-bit ALU control. It also recognises `mult`, `multu`, `div`, `divu`, `mfhi` and `mflo`, runs the multi-cycle arithmetic and raises a stall to the datapath while results are pending.

---
 rtl/alu_decoder_md.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_decoder_md.sv
`default_nettype none
// ============================================================================
//  Module      : alu_decoder_md
//  Description : MIPS ALU control decoder with an iterative shift-add
//                multiplier / restoring divider and the HI/LO register pair.
//                Stalls the datapath while a multiply/divide is in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder_md #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [1:0]        aluop,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] srca,
    input  logic [DATA_W-1:0] srcb,
    output logic [2:0]        alucontrol,
    output logic              md_busy,
    output logic              stall,
    output logic [DATA_W-1:0] md_result,
    output logic              div_zero
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DATA_W - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_mul  = 2'd1;
    localparam logic [1:0] c_st_div  = 2'd2;
    localparam logic [1:0] c_st_fix  = 2'd3;

    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_and   = 6'b100100;
    localparam logic [5:0] c_fn_or    = 6'b100101;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_mult  = 6'b011000;
    localparam logic [5:0] c_fn_multu = 6'b011001;
    localparam logic [5:0] c_fn_div   = 6'b011010;
    localparam logic [5:0] c_fn_divu  = 6'b011011;
    localparam logic [5:0] c_fn_mfhi  = 6'b010000;
    localparam logic [5:0] c_fn_mflo  = 6'b010010;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_hi;
    logic [DATA_W-1:0]   r_lo;
    logic [DATA_W-1:0]   r_acc_hi;
    logic [DATA_W-1:0]   r_acc_lo;
    logic [DATA_W-1:0]   r_m;
    logic [DATA_W-1:0]   r_dividend;
    logic                r_neg_a;
    logic                r_neg_b;
    logic                r_is_div;

    logic                w_rtype;
    logic                w_op_mult, w_op_multu, w_op_div, w_op_divu;
    logic                w_op_mfhi, w_op_mflo;
    logic                w_md_arith, w_md_move, w_is_divop, w_signed_op;
    logic                w_start;
    logic                w_neg_a, w_neg_b;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b;
    logic [DATA_W:0]     w_mul_sum;
    logic [DATA_W:0]     w_div_shift;
    logic [DATA_W:0]     w_div_trial;
    logic                w_div_by_zero;
    logic [2*DATA_W-1:0] w_prod_raw;
    logic [2*DATA_W-1:0] w_prod_neg;
    logic [DATA_W-1:0]   w_fix_hi, w_fix_lo;

    // MD instructions only exist in the R-type (aluop = 10) space
    assign w_rtype     = (aluop == 2'b10);
    assign w_op_mult   = w_rtype && (funct == c_fn_mult);
    assign w_op_multu  = w_rtype && (funct == c_fn_multu);
    assign w_op_div    = w_rtype && (funct == c_fn_div);
    assign w_op_divu   = w_rtype && (funct == c_fn_divu);
    assign w_op_mfhi   = w_rtype && (funct == c_fn_mfhi);
    assign w_op_mflo   = w_rtype && (funct == c_fn_mflo);
    assign w_md_arith  = w_op_mult | w_op_multu | w_op_div | w_op_divu;
    assign w_md_move   = w_op_mfhi | w_op_mflo;
    assign w_is_divop  = w_op_div | w_op_divu;
    assign w_signed_op = w_op_mult | w_op_div;

    assign md_busy = (r_state != c_st_idle);
    assign stall   = valid_in && (w_md_arith || w_md_move) && md_busy;
    // Being in IDLE already implies no stall, so no extra stall term here
    assign w_start = valid_in && w_md_arith && (r_state == c_st_idle);

    // Signed operands are reduced to magnitudes; the signs come back in FIX
    assign w_neg_a = w_signed_op & srca[DATA_W-1];
    assign w_neg_b = w_signed_op & srcb[DATA_W-1];
    assign w_mag_a = w_neg_a ? (-srca) : srca;
    assign w_mag_b = w_neg_b ? (-srcb) : srcb;

    // One multiplier bit per cycle: add when the LSB of the multiplier is set
    assign w_mul_sum = r_acc_lo[0] ? ({1'b0, r_acc_hi} + {1'b0, r_m}) : {1'b0, r_acc_hi};

    // Restoring step: shift next dividend bit into the partial remainder
    assign w_div_shift = {r_acc_hi, r_acc_lo[DATA_W-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_m};

    assign w_div_by_zero = (r_m == '0);
    assign w_prod_raw    = {r_acc_hi, r_acc_lo};
    assign w_prod_neg    = -w_prod_raw;

    // A zero divisor is flagged only as the operation completes, never under reset
    assign div_zero = (r_state == c_st_fix) && r_is_div && w_div_by_zero && !rst;

    // ALU control decode from op class and function field
    always_comb begin
        alucontrol = 3'b010;
        case (aluop)
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    c_fn_add: alucontrol = 3'b010;
                    c_fn_sub: alucontrol = 3'b110;
                    c_fn_and: alucontrol = 3'b000;
                    c_fn_or:  alucontrol = 3'b001;
                    c_fn_slt: alucontrol = 3'b111;
                    default:  alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b010;
        endcase
    end

    // HI/LO read port; a stalled move must not see stale values
    always_comb begin
        md_result = '0;
        if (!stall) begin
            if (w_op_mfhi) begin
                md_result = r_hi;
            end else if (w_op_mflo) begin
                md_result = r_lo;
            end
        end
    end

    // Sign correction and divide-by-zero override applied in the FIX cycle
    always_comb begin
        w_fix_hi = w_prod_raw[2*DATA_W-1:DATA_W];
        w_fix_lo = w_prod_raw[DATA_W-1:0];
        if (r_is_div) begin
            if (w_div_by_zero) begin
                w_fix_hi = r_dividend;
                w_fix_lo = '1;
            end else begin
                w_fix_lo = (r_neg_a ^ r_neg_b) ? (-r_acc_lo) : r_acc_lo;
                w_fix_hi = r_neg_a ? (-r_acc_hi) : r_acc_hi;
            end
        end else if (r_neg_a ^ r_neg_b) begin
            w_fix_hi = w_prod_neg[2*DATA_W-1:DATA_W];
            w_fix_lo = w_prod_neg[DATA_W-1:0];
        end
    end

    // Sequencer next-state: IDLE -> MUL/DIV -> FIX -> IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_state_nxt = w_is_divop ? c_st_div : c_st_mul;
                end
            end
            c_st_mul, c_st_div: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_fix;
                end
            end
            c_st_fix: w_state_nxt = c_st_idle;
            default:  w_state_nxt = c_st_idle;
        endcase
    end

    // Sequencer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, iteration datapath and HI/LO write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_m        <= '0;
            r_dividend <= '0;
            r_neg_a    <= 1'b0;
            r_neg_b    <= 1'b0;
            r_is_div   <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_cnt      <= '0;
                        r_is_div   <= w_is_divop;
                        r_neg_a    <= w_neg_a;
                        r_neg_b    <= w_neg_b;
                        r_dividend <= srca;
                        r_acc_hi   <= '0;
                        if (w_is_divop) begin
                            r_m      <= w_mag_b;
                            r_acc_lo <= w_mag_a;
                        end else begin
                            r_m      <= w_mag_a;
                            r_acc_lo <= w_mag_b;
                        end
                    end
                end
                c_st_mul: begin
                    r_acc_hi <= w_mul_sum[DATA_W:1];
                    r_acc_lo <= {w_mul_sum[0], r_acc_lo[DATA_W-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                c_st_div: begin
                    if (!w_div_trial[DATA_W]) begin
                        r_acc_hi <= w_div_trial[DATA_W-1:0];
                        r_acc_lo <= {r_acc_lo[DATA_W-2:0], 1'b1};
                    end else begin
                        r_acc_hi <= w_div_shift[DATA_W-1:0];
                        r_acc_lo <= {r_acc_lo[DATA_W-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                c_st_fix: begin
                    r_hi <= w_fix_hi;
                    r_lo <= w_fix_lo;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
